// File: rtl/nibble_key_sched.sv
// Nibble-serial key scheduler: pairs each accepted plaintext nibble with its
// XOR against the next key nibble and presents both, plus the select, as a registered triple.
module nibble_key_sched #(
  parameter int KEY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             in_valid,
  input  logic [3:0]       in_nib,
  input  logic             enc_en,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       in1,
  output logic [3:0]       in2,
  output logic             sel,
  output logic             key_valid,
  output logic [15:0]      nib_cnt
);

  localparam int NIBS  = KEY_W / 4;
  localparam int PTR_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NIBS - 1);

  typedef enum logic [0:0] {
    NOKEY = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       in1_q, in1_d;
  logic [3:0]       in2_q, in2_d;
  logic             sel_q, sel_d;
  logic             ov_q, ov_d;
  logic             accept_s;
  logic             consume_s;
  logic [3:0]       key_nib_s;

  assign key_valid = (state_q == RUN);
  assign in_ready  = key_valid && !key_load && (!ov_q || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign consume_s = ov_q && out_ready;
  assign key_nib_s = key_q[{ptr_q, 2'b00} +: 4];

  assign out_valid = ov_q;
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign sel       = sel_q;
  assign nib_cnt   = cnt_q;

  // Next-state: key/pointer/count bookkeeping and the output triple
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    sel_d   = sel_q;
    ov_d    = ov_q;

    case (state_q)
      NOKEY: begin
        if (key_load) begin
          state_d = RUN;
        end else begin
          state_d = NOKEY;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = NOKEY;
    endcase

    // key_load never coincides with accept because it forces in_ready low
    if (key_load) begin
      key_d = key_in;
      ptr_d = {PTR_W{1'b0}};
      cnt_d = 16'd0;
    end else if (accept_s) begin
      if (ptr_q == PTR_LAST) begin
        ptr_d = {PTR_W{1'b0}};
      end else begin
        ptr_d = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      cnt_d = cnt_q + 16'd1;
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end

    if (accept_s) begin
      in1_d = in_nib;
      in2_d = in_nib ^ key_nib_s;
      sel_d = enc_en;
      ov_d  = 1'b1;
    end else if (consume_s) begin
      ov_d  = 1'b0;
    end else begin
      ov_d  = ov_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NOKEY;
      key_q   <= {KEY_W{1'b0}};
      ptr_q   <= {PTR_W{1'b0}};
      cnt_q   <= 16'd0;
      in1_q   <= 4'h0;
      in2_q   <= 4'h0;
      sel_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sel_q   <= sel_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: doc/nibble_key_sched.md
NIBBLE_KEY_SCHED -- requirements
Module: nibble_key_sched

Interface
REQ-001 SHALL have parameter: KEY_W, 16, key width in bits; multiple of 4, range 8..64.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: key_load  input  1  load key_in into key register this cycle.
REQ-005 SHALL have port: key_in  input  KEY_W  cipher key.
REQ-006 SHALL have port: in_valid  input  1  in_nib is presented.
REQ-007 SHALL have port: in_nib  input  4  plaintext nibble.
REQ-008 SHALL have port: enc_en  input  1  1 = select cipher path for this nibble; 0 = pass plaintext.
REQ-009 SHALL have port: in_ready  output  1  nibble accepted when in_valid && in_ready.
REQ-010 SHALL have port: out_valid  output  1  in1/in2/sel hold a valid triple.
REQ-011 SHALL have port: out_ready  input  1  downstream consumes triple when out_valid && out_ready.
REQ-012 SHALL have port: in1  output  4  registered plaintext nibble (mux input 0).
REQ-013 SHALL have port: in2  output  4  registered in_nib XOR key nibble (mux input 1).
REQ-014 SHALL have port: sel  output  1  registered mux select (enc_en captured with the nibble).
REQ-015 SHALL have port: key_valid  output  1  a key has been loaded since reset.
REQ-016 SHALL have port: nib_cnt  output  16  count of accepted nibbles since reset or last key_load.

Function
REQ-017 SHALL implement state machine NOKEY -> RUN; NOKEY on reset, RUN after first key_load; no return to NOKEY except by rst.
REQ-018 SHALL drive key_valid = 1 exactly in RUN.
REQ-019 SHALL compute in_ready = key_valid && !key_load && (!out_valid || out_ready), combinationally.
REQ-020 SHALL in NOKEY keep in_ready = 0; in_valid ignored, no nibble lost (source holds).
REQ-021 SHALL on key_load: key register <= key_in, nibble pointer ptr <= 0, nib_cnt <= 0, next cycle.
REQ-022 SHALL give key_load priority over acceptance; no nibble accepted in a key_load cycle.
REQ-023 SHALL leave a pending output triple (out_valid = 1) unchanged by key_load; it stays encrypted with the old key.
REQ-024 SHALL on accept, next cycle: in1 <= in_nib; in2 <= in_nib ^ key[4*ptr+3:4*ptr]; sel <= enc_en; out_valid <= 1.
REQ-025 SHALL have latency of exactly 1 cycle from accept to out_valid; throughput 1 nibble/cycle with out_ready held high.
REQ-026 SHALL advance ptr by 1 per accept, wrapping from KEY_W/4-1 to 0.
REQ-027 SHALL increment nib_cnt by 1 per accept, wrapping 0xFFFF -> 0x0000.
REQ-028 SHALL clear out_valid on consume when no new accept in the same cycle; consume+accept same cycle keeps out_valid = 1 with new data.
REQ-029 SHALL hold in1/in2/sel stable while out_valid && !out_ready.
REQ-030 SHALL hold in1/in2/sel at last value when out_valid = 0 (content don't-care downstream).

Reset
REQ-031 SHALL on rst = 1 at a clock edge set: state NOKEY, key register 0, ptr 0, nib_cnt 0, in1 0, in2 0, sel 0, out_valid 0, key_valid 0.
REQ-032 SHALL have rst override key_load, accept and consume in the same cycle.
REQ-033 SHALL discard a pending triple when rst is asserted mid-operation; no out_valid in the cycle after reset.

Verification (KEY_W = 16)
REQ-034 SHALL cover: rst, then in_valid = 1 with no key for 5 cycles -> in_ready = 0, out_valid = 0, nib_cnt = 0.
REQ-035 SHALL cover: key_load with key_in = 0xA5C3, then nibbles 6,F,0,1,2 with enc_en = 1, out_ready = 1 -> in2 = 5,3,5,B,1 (wrap to key nibble 3); in1 = inputs; sel = 1; nib_cnt = 5.
REQ-036 SHALL cover: out_ready = 0 for 3 cycles with out_valid = 1 -> in_ready = 0, in1/in2/sel stable; out_ready = 1 -> triple consumed, next nibble accepted same cycle.
REQ-037 SHALL cover: key_load = 0x1111 with in_valid = 1 while triple pending -> no accept that cycle, pending in2 unchanged, next accepted nibble 0x4 -> in2 = 0x5, nib_cnt = 1.
REQ-038 SHALL cover: enc_en = 0 with in_nib = 0x9 -> sel = 0, in1 = 0x9, in2 = 0x9 ^ key nibble.
REQ-039 SHALL cover: rst asserted while out_valid = 1 and key_load = 1 -> next cycle all outputs 0, key_valid = 0.
